qam_demodulation: RTL and testbench

- Receive-side counterpart of the QAM modulator; consumes the modulator's sample strobe `clk_m`, alignment marker `m_align` and 3-bit amplitude code `A_reg`.
- Recovers I/Q symbol framing, Gray-decodes each axis, and emits 6-bit symbols with a valid pulse.
- Maintains lock/loss state and a saturating error counter.
- Sits between the modulator output (or channel model) and downstream bit sinks.

---
 rtl/qam_pkg.sv | 15 +
 rtl/qam_edge_sync.sv | 29 ++
 rtl/qam_demodulation.sv | 98 +++++++++
 tb/tb_qam_demodulation.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// qam_pkg: shared QAM symbol widths, receiver framing states and Gray code helpers.
package qam_pkg;
  localparam int SYM_W = 6;
  localparam int AXIS_W = 3;
  typedef enum logic [1:0] {HUNT, WAIT_Q, WAIT_I} state_t;
  function automatic logic [AXIS_W-1:0] gray2bin(input logic [AXIS_W-1:0] g);
    logic [AXIS_W-1:0] b;
    b[AXIS_W-1] = g[AXIS_W-1];
    for (int i = AXIS_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [AXIS_W-1:0] bin2gray(input logic [AXIS_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/qam_edge_sync.sv
// qam_edge_sync: registers the modulator inputs and detects clk_m rising edges in the clk domain.
module qam_edge_sync
  import qam_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_m,
  input  logic              m_align,
  input  logic [AXIS_W-1:0] A_reg,
  output logic              strobe,
  output logic              m_align_s,
  output logic [AXIS_W-1:0] A_s
);
  logic clk_m_s1_q, clk_m_s2_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_m_s1_q <= 1'b0;
      clk_m_s2_q <= 1'b0;
      m_align_s  <= 1'b0;
      A_s        <= '0;
    end else begin
      clk_m_s1_q <= clk_m;
      clk_m_s2_q <= clk_m_s1_q;
      m_align_s  <= m_align;
      A_s        <= A_reg;
    end
  end
  assign strobe = clk_m_s1_q & ~clk_m_s2_q;
endmodule

// File: rtl/qam_demodulation.sv
// qam_demodulation: recovers I/Q framing from the modulator strobe, Gray-decodes symbols,
// and tracks lock, loss and timeout with a saturating error counter.
module qam_demodulation
  import qam_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_m,
  input  logic              m_align,
  input  logic [AXIS_W-1:0] A_reg,
  output logic [SYM_W-1:0]  sym_data,
  output logic              sym_valid,
  output logic              locked,
  output logic [7:0]        err_cnt
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  state_t            state_q;
  logic [GW-1:0]     good_q;
  logic [MW-1:0]     miss_q;
  logic [IW-1:0]     idle_q;
  logic [AXIS_W-1:0] i_q;
  logic [SYM_W-1:0]  sym_data_q;
  logic              sym_valid_q, locked_q;
  logic [7:0]        err_q, err_d;
  logic              strobe, m_align_s, fr_err, q_ok, timeout, loss;
  logic [AXIS_W-1:0] a_s;

  qam_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .clk_m    (clk_m),
    .m_align  (m_align),
    .A_reg    (A_reg),
    .strobe   (strobe),
    .m_align_s(m_align_s),
    .A_s      (a_s)
  );

  // A strobe always wins over the idle terminal count, so timeout requires !strobe.
  always_comb begin
    fr_err  = strobe && (state_q == WAIT_Q ? m_align_s : (state_q == WAIT_I && !m_align_s));
    q_ok    = strobe && state_q == WAIT_Q && !m_align_s;
    timeout = !strobe && state_q != HUNT && idle_q == IW'(TIMEOUT - 1);
    loss    = fr_err && locked_q && miss_q == MW'(LOSS_COUNT - 1);
    err_d   = (fr_err || timeout) && err_q != 8'hff ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HUNT;
      good_q      <= '0;
      miss_q      <= '0;
      idle_q      <= '0;
      i_q         <= '0;
      sym_data_q  <= '0;
      sym_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      sym_valid_q <= 1'b0;
      err_q       <= err_d;
      idle_q      <= (state_q == HUNT || strobe) ? '0 : idle_q + 1'b1;
      if (strobe && m_align_s) i_q <= gray2bin(a_s);
      if (timeout || loss) begin
        state_q  <= HUNT;
        locked_q <= 1'b0;
        good_q   <= '0;
        miss_q   <= '0;
        idle_q   <= '0;
      end else if (fr_err) begin
        good_q <= '0;
        miss_q <= miss_q == MW'(LOSS_COUNT) ? miss_q : miss_q + 1'b1;
      end else if (q_ok) begin
        state_q <= WAIT_I;
        miss_q  <= '0;
        good_q  <= good_q == GW'(LOCK_COUNT) ? good_q : good_q + 1'b1;
        if (good_q >= GW'(LOCK_COUNT - 1)) locked_q <= 1'b1;
        if (locked_q) begin
          sym_valid_q <= 1'b1;
          sym_data_q  <= {i_q, gray2bin(a_s)};
        end
      end else if (strobe && m_align_s) begin
        state_q <= WAIT_Q;
      end
    end
  end

  assign sym_data  = sym_data_q;
  assign sym_valid = sym_valid_q;
  assign locked    = locked_q;
  assign err_cnt   = err_q;
endmodule

// File: tb/tb_qam_demodulation.sv
// tb_qam_demodulation: directed stimulus with a symbol scoreboard and a decoupled output monitor.
module tb_qam_demodulation;
  logic       clk, rst, clk_m, m_align;
  logic [2:0] A_reg;
  logic [5:0] sym_data;
  logic       sym_valid, locked;
  logic [7:0] err_cnt;
  int         checks = 0, errors = 0;
  logic [5:0] sb[$];

  qam_demodulation dut (
    .clk      (clk),
    .rst      (rst),
    .clk_m    (clk_m),
    .m_align  (m_align),
    .A_reg    (A_reg),
    .sym_data (sym_data),
    .sym_valid(sym_valid),
    .locked   (locked),
    .err_cnt  (err_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (sym_valid) begin
      logic [5:0] e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sym_unexpected: got %b, expected no sym_valid", sym_data);
      end else begin
        e = sb.pop_front();
        if (sym_data !== e) begin
          errors++;
          $display("FAIL sym_data: got %b, expected %b", sym_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic al, input logic [2:0] a);
    m_align = al;
    A_reg   = a;
    clk_m   = 1;
    tick(4);
    clk_m = 0;
    tick(4);
  endtask

  task automatic pair(input logic [2:0] i, input logic [2:0] q, input logic push, input logic [5:0] exp);
    send(1, i);
    if (push) sb.push_back(exp);
    send(0, q);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sym_data"}, int'(sym_data), 0);
    chk({tag, "_sym_valid"}, int'(sym_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  initial begin
    rst = 0; clk_m = 0; m_align = 0; A_reg = 0;
    tick(3);
    chk_reset("rst");
    rst = 1;
    tick(2);
    for (int n = 0; n < 3; n++) pair(3'b110, 3'b011, 0, '0);
    chk("prelock", int'(locked), 0);
    pair(3'b110, 3'b011, 0, '0);
    chk("lock_4th", int'(locked), 1);
    send(1, 3'b110);
    m_align = 0; A_reg = 3'b011; clk_m = 1;
    sb.push_back(6'b100_010);
    tick(1); chk("lat_edge1", int'(sym_valid), 0);
    tick(1); chk("lat_edge2", int'(sym_valid), 1);
    tick(1); chk("lat_edge3", int'(sym_valid), 0);
    tick(1); clk_m = 0; tick(4);
    pair(3'b110, 3'b011, 1, 6'b100_010);
    pair(3'b000, 3'b111, 1, 6'b000_101);
    pair(3'b101, 3'b001, 1, 6'b110_001);
    pair(3'b010, 3'b100, 1, 6'b011_111);
    chk("err_before_loss", int'(err_cnt), 0);
    send(1, 3'b110);
    send(1, 3'b011);
    send(1, 3'b011);
    chk("locked_after_2err", int'(locked), 1);
    send(1, 3'b011);
    chk("loss_err_cnt", int'(err_cnt), 3);
    chk("loss_unlocked", int'(locked), 0);
    for (int n = 0; n < 3; n++) pair(3'b110, 3'b011, 0, '0);
    chk("relock_pending", int'(locked), 0);
    pair(3'b110, 3'b011, 0, '0);
    chk("relock", int'(locked), 1);
    pair(3'b110, 3'b011, 1, 6'b100_010);
    tick(57);
    chk("timeout_edge63", int'(locked), 1);
    tick(1);
    chk("timeout_edge64", int'(locked), 0);
    chk("timeout_err_cnt", int'(err_cnt), 4);
    send(1, 3'b000);
    for (int n = 0; n < 251; n++) send(1, 3'b000);
    chk("sat_reach", int'(err_cnt), 255);
    for (int n = 0; n < 49; n++) send(1, 3'b000);
    chk("sat_hold", int'(err_cnt), 255);
    send(1, 3'b110);
    rst = 0;
    tick(1);
    rst = 1;
    chk_reset("midrst");
    send(0, 3'b011);
    chk("midrst_q_ignored_err", int'(err_cnt), 0);
    for (int n = 0; n < 3; n++) pair(3'b110, 3'b011, 0, '0);
    chk("midrst_prelock", int'(locked), 0);
    pair(3'b110, 3'b011, 0, '0);
    chk("midrst_lock", int'(locked), 1);
    pair(3'b110, 3'b011, 1, 6'b100_010);
    tick(10);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
